// File: rtl/cxu_alu_target.sv
// rtl/cxu_alu_target.sv - CXU-LI target: 1-cycle integer ops, iterative multiply, held response
module cxu_alu_target #(
    parameter int CXU_FUNC_ID_W  = 3,
    parameter int CXU_DATA_W     = 32,
    parameter int CXU_CXU_ID_W   = 2,
    parameter int CXU_STATE_ID_W = 1,
    parameter int CXU_INSN_W     = 1
) (
    input  logic                      CLK,
    input  logic                      rst,
    input  logic                      UserCLK_en,
    input  logic                      req_valid,
    output logic                      req_ready,
    input  logic [CXU_CXU_ID_W-1:0]   req_cxu,
    input  logic [CXU_STATE_ID_W-1:0] req_state,
    input  logic [CXU_FUNC_ID_W-1:0]  req_func,
    input  logic [CXU_INSN_W-1:0]     req_insn,
    input  logic [CXU_DATA_W-1:0]     req_data0,
    input  logic [CXU_DATA_W-1:0]     req_data1,
    output logic                      resp_valid,
    input  logic                      resp_ready,
    output logic [2:0]                resp_status,
    output logic [CXU_DATA_W-1:0]     resp_data
);

    localparam int CNT_W = $clog2(CXU_DATA_W) + 1;

    localparam logic [CXU_FUNC_ID_W-1:0] F_ADD = CXU_FUNC_ID_W'(0);
    localparam logic [CXU_FUNC_ID_W-1:0] F_SUB = CXU_FUNC_ID_W'(1);
    localparam logic [CXU_FUNC_ID_W-1:0] F_AND = CXU_FUNC_ID_W'(2);
    localparam logic [CXU_FUNC_ID_W-1:0] F_XOR = CXU_FUNC_ID_W'(3);
    localparam logic [CXU_FUNC_ID_W-1:0] F_POP = CXU_FUNC_ID_W'(4);
    localparam logic [CXU_FUNC_ID_W-1:0] F_MUL = CXU_FUNC_ID_W'(5);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MUL  = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t                  state;
    logic [CXU_DATA_W-1:0]   mcand;
    logic [CXU_DATA_W-1:0]   mplier;
    logic [CXU_DATA_W-1:0]   acc;
    logic [CNT_W-1:0]        cnt;

    logic [CNT_W-1:0]        pop;
    logic [CXU_DATA_W-1:0]   alu_data;
    logic [2:0]              alu_status;
    logic [CXU_DATA_W-1:0]   acc_next;

    // Routing, state and instruction fields carry no meaning for a stateless ALU.
    logic unused_fields;
    assign unused_fields = ^{req_cxu, req_state, req_insn};

    assign req_ready = (state == IDLE) & UserCLK_en;
    assign acc_next  = mplier[0] ? acc + mcand : acc;

    // Population count of operand A; the result always fits in the counter width.
    always_comb begin
        pop = '0;
        for (int i = 0; i < CXU_DATA_W; i++) begin
            pop = pop + CNT_W'(req_data0[i]);
        end
    end

    // Single-cycle function results; unsupported codes report an error with zero data.
    always_comb begin
        alu_data   = '0;
        alu_status = 3'd0;
        case (req_func)
            F_ADD:   alu_data = req_data0 + req_data1;
            F_SUB:   alu_data = req_data0 - req_data1;
            F_AND:   alu_data = req_data0 & req_data1;
            F_XOR:   alu_data = req_data0 ^ req_data1;
            F_POP:   alu_data = CXU_DATA_W'(pop);
            default: alu_status = 3'd1;
        endcase
    end

    // Control FSM with shift-add multiplier; everything freezes while UserCLK_en is low.
    always_ff @(posedge CLK or negedge rst) begin
        if (!rst) begin
            state       <= IDLE;
            resp_valid  <= 1'b0;
            resp_status <= 3'd0;
            resp_data   <= '0;
            mcand       <= '0;
            mplier      <= '0;
            acc         <= '0;
            cnt         <= '0;
        end else if (UserCLK_en) begin
            case (state)
                IDLE: begin
                    if (req_valid) begin
                        if (req_func == F_MUL) begin
                            mcand  <= req_data0;
                            mplier <= req_data1;
                            acc    <= '0;
                            cnt    <= '0;
                            state  <= MUL;
                        end else begin
                            resp_data   <= alu_data;
                            resp_status <= alu_status;
                            resp_valid  <= 1'b1;
                            state       <= RESP;
                        end
                    end
                end
                MUL: begin
                    acc    <= acc_next;
                    mcand  <= {mcand[CXU_DATA_W-2:0], 1'b0};
                    mplier <= {1'b0, mplier[CXU_DATA_W-1:1]};
                    cnt    <= cnt + 1'b1;
                    // Fixed latency: always run all DATA_W steps, no early exit.
                    if (cnt == CNT_W'(CXU_DATA_W - 1)) begin
                        resp_data   <= acc_next;
                        resp_status <= 3'd0;
                        resp_valid  <= 1'b1;
                        state       <= RESP;
                    end
                end
                RESP: begin
                    if (resp_ready) begin
                        resp_valid <= 1'b0;
                        state      <= IDLE;
                    end
                end
                default: begin
                    resp_valid <= 1'b0;
                    state      <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: doc/cxu_alu_target.md
Name: cxu_alu_target

Overview:
- CXU-LI target unit that consumes the per-target request/response channel (t_req_*/t_resp_*) driven by the 4-way CXU mux.
- One instance sits behind each mux port.
- Executes simple integer functions with 1-cycle latency; executes multiply iteratively over DATA_W cycles.
- Holds each response until the mux accepts it.

Parameters:
CXU_FUNC_ID_W, 3, width of req_func
CXU_DATA_W, 32, operand/result width; must be >=2
CXU_CXU_ID_W, 2, width of req_cxu (ignored by this unit)
CXU_STATE_ID_W, 1, width of req_state (stateless unit; ignored)
CXU_INSN_W, 1, width of req_insn (ignored)

Ports:
CLK  in  1  clock
rst  in  1  asynchronous active-low reset
UserCLK_en  in  1  clock enable; when 0, all registers hold
req_valid  in  1  request valid
req_ready  out  1  unit can accept request
req_cxu  in  CXU_CXU_ID_W  target id (ignored)
req_state  in  CXU_STATE_ID_W  state id (ignored)
req_func  in  CXU_FUNC_ID_W  function code
req_insn  in  CXU_INSN_W  raw insn bits (ignored)
req_data0  in  CXU_DATA_W  operand A
req_data1  in  CXU_DATA_W  operand B
resp_valid  out  1  response valid
resp_ready  in  1  consumer accepts response
resp_status  out  3  0=success, 1=error (unsupported func)
resp_data  out  CXU_DATA_W  result

Behaviour:
- Reset (rst=0, asynchronous): state=IDLE, resp_valid=0, resp_status=0, resp_data=0, multiply counter/accumulators=0. Reset aborts any in-flight multiply or pending response; no response is ever emitted for it.
- FSM states: IDLE, MUL, RESP. All transitions and register updates occur only on CLK edges with UserCLK_en=1.
- req_ready = (state==IDLE) & UserCLK_en, combinational. resp_valid = (state==RESP), registered.
- Accept: req_valid & req_ready at an enabled edge; operands are captured.
- Response transfer: resp_valid & resp_ready & UserCLK_en at an edge.
- IDLE, accept, func 0-4 or 6-7: result computed from the request inputs and registered into resp_data/resp_status; next state RESP. Latency: resp_valid asserts the cycle after accept.
- Function codes:
  - 0 ADD: A+B mod 2^DATA_W
  - 1 SUB: A-B mod 2^DATA_W
  - 2 AND: A&B
  - 3 XOR: A^B
  - 4 POPCNT: number of 1s in A, zero-extended; B ignored
  - 5 MUL: low DATA_W bits of A*B, unsigned
  - 6, 7: status=1, data=0
- IDLE, accept, func 5: capture multiplicand=A and multiplier=B; clear accumulator; counter=0; go to MUL.
- MUL, each enabled cycle:
  - if multiplier[0], acc += multiplicand
  - multiplicand <<= 1; multiplier >>= 1; counter++
  - after the DATA_W-th step, load acc into resp_data with status=0 and go to RESP.
  - resp_valid first asserts DATA_W+1 enabled cycles after accept (33 for default).
  - Early termination is not permitted; latency is fixed.
- RESP: resp_data/resp_status are stable while resp_valid=1. On transfer, go to IDLE. req_ready stays 0 throughout RESP, so there is no accept in the same cycle as the transfer; minimum issue interval is 2 cycles.
- resp_ready low in RESP: hold indefinitely. resp_ready asserted in IDLE/MUL: no effect.
- UserCLK_en=0 in any state: freezes FSM, counter and datapath. req_ready is 0. resp_valid keeps its value, but no transfer is counted.
- req_valid in MUL/RESP: ignored (req_ready=0); the requester must hold the request.
- Width rule: counter is $clog2(CXU_DATA_W)+1 bits; POPCNT result fits in that width and is zero-extended to DATA_W.

Test Plan:
- Reset, then ADD A=0xFFFFFFFF B=2, resp_ready=1 -> resp_valid at cycle+1, data=0x00000001, status=0; req_ready back to 1 one cycle after transfer.
- SUB A=0 B=1 -> 0xFFFFFFFF; POPCNT A=0xF0F00001 -> 9; func 6 -> status=1, data=0.
- MUL A=0x0001_0003 B=0x0000_0005 -> resp_valid exactly 33 cycles after accept, data=0x0005_000F. MUL A=0xFFFFFFFF B=0xFFFFFFFF -> 0x00000001.
- Backpressure: resp_ready=0 for 10 cycles after resp_valid -> data/status stable, req_ready=0; a new req_valid is ignored until resp_ready=1 completes the transfer.
- UserCLK_en=0 for 5 cycles mid-MUL -> completion delayed by exactly 5 cycles and result unchanged. UserCLK_en=0 while in RESP with resp_ready=1 -> no transfer.
- Assert rst=0 at cycle 10 of a MUL -> resp_valid=0 immediately. After release, an ADD 3+4 returns 7 with no stale MUL response.
